// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage feeding a circular FIFO.
//   Each accepted instruction is decoded into an rv32i_control_word. The word
//   is stored together with the PC, the raw instruction and an illegal flag.
//   The head entry is held in an output register, so there is no combinational
//   path from in_* to out_*.
// Optional build macro: DECODE_RV32M_EN. When it is defined, the queue accepts
//   the M extension (op_reg funct7=0000001) and adds the out_muldiv and
//   out_mdop ports.
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   in_valid/in_ready  fetch handshake (in_ready = count < DEPTH)
//   in_instr, in_pc    raw instruction word and its PC
//   flush              discards every queued entry
//   out_valid/out_ready issue handshake on the head entry
//   out_ctrl, out_pc, out_instr, out_illegal   head entry contents
//   out_muldiv, out_mdop   (DECODE_RV32M_EN only) M-extension op and funct3
//   count              current occupancy
package decode_queue_pkg;
   typedef enum logic [6:0] {
      op_lui   = 7'b0110111, op_auipc = 7'b0010111, op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111, op_br    = 7'b1100011, op_load  = 7'b0000011,
      op_store = 7'b0100011, op_imm   = 7'b0010011, op_reg   = 7'b0110011
   } rv32i_opcode_t;

   // add/sll/xor/srl/or/and sit at their funct3 codes. The slt/sltu slots (2, 3)
   // are free because those ops use the comparator, so they hold sra/sub.
   typedef enum logic [2:0] {
      alu_add = 3'd0, alu_sll = 3'd1, alu_sra = 3'd2, alu_sub = 3'd3,
      alu_xor = 3'd4, alu_srl = 3'd5, alu_or  = 3'd6, alu_and = 3'd7
   } alu_ops_t;

   typedef enum logic [2:0] {
      beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
   } branch_funct3_t;

   typedef enum logic       {alumux1_rs1 = 1'b0, alumux1_pc = 1'b1} alumux1_sel_t;
   typedef enum logic [2:0] {
      alumux2_i_imm = 3'd0, alumux2_u_imm = 3'd1, alumux2_b_imm = 3'd2,
      alumux2_s_imm = 3'd3, alumux2_j_imm = 3'd4, alumux2_rs2 = 3'd5
   } alumux2_sel_t;
   typedef enum logic       {cmpmux_rs2 = 1'b0, cmpmux_i_imm = 1'b1} cmpmux_sel_t;
   // pcmux_br means: take alu_out when the comparator reports br_en.
   typedef enum logic [1:0] {
      pcmux_pc_plus4 = 2'd0, pcmux_alu_out = 2'd1, pcmux_alu_mod2 = 2'd2, pcmux_br = 2'd3
   } pcmux_sel_t;
   typedef enum logic [3:0] {
      rfmux_alu_out = 4'd0, rfmux_br_en = 4'd1, rfmux_u_imm = 4'd2, rfmux_lw  = 4'd3,
      rfmux_pc_plus4 = 4'd4, rfmux_lb  = 4'd5, rfmux_lbu   = 4'd6, rfmux_lh  = 4'd7,
      rfmux_lhu = 4'd8
   } regfilemux_sel_t;

   typedef struct packed {
      rv32i_opcode_t   opcode;
      alu_ops_t        aluop;
      alumux1_sel_t    alumux1_sel;
      alumux2_sel_t    alumux2_sel;
      branch_funct3_t  cmpop;
      cmpmux_sel_t     cmpmux_sel;
      logic            use_cmp;
      pcmux_sel_t      pcmux_sel;
      regfilemux_sel_t regfilemux_sel;
      logic            regfile_wb;
      logic            rs1_read;
      logic            rs2_read;
      logic            d_read;
      logic            d_write;
      logic [3:0]      byte_enable;
   } rv32i_control_word;
endpackage

module decode_queue import decode_queue_pkg::*; #(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output rv32i_control_word out_ctrl,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic              out_illegal,
`ifdef DECODE_RV32M_EN
   output logic              out_muldiv,
   output logic [2:0]        out_mdop,
`endif
   output logic [CNT_W-1:0]  count
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      rv32i_control_word ctrl;
      logic [31:0]       pc;
      logic [31:0]       instr;
      logic              illegal;
`ifdef DECODE_RV32M_EN
      logic              muldiv;
      logic [2:0]        mdop;
`endif
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head_q, dec;
   logic [PTR_W-1:0] head, tail, head_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             push, pop, bypass;
   logic [2:0]       funct3;
   logic [6:0]       funct7;

   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // ---------------- decode ----------------
   // NOTE: every field gets a default first, so no path leaves a latch behind.
   always_comb begin
      dec                     = '0;
      dec.pc                  = in_pc;
      dec.instr               = in_instr;
      dec.ctrl.opcode         = rv32i_opcode_t'(in_instr[6:0]);
      dec.ctrl.aluop          = alu_ops_t'(funct3);
      dec.ctrl.cmpop          = branch_funct3_t'(funct3);
      dec.ctrl.alumux1_sel    = alumux1_rs1;
      dec.ctrl.alumux2_sel    = alumux2_i_imm;
      dec.ctrl.cmpmux_sel     = cmpmux_rs2;
      dec.ctrl.pcmux_sel      = pcmux_pc_plus4;
      dec.ctrl.regfilemux_sel = rfmux_alu_out;
      case (in_instr[6:0])
         op_auipc: begin
            dec.ctrl.alumux1_sel = alumux1_pc;
            dec.ctrl.alumux2_sel = alumux2_u_imm;
            dec.ctrl.regfile_wb  = 1'b1;
         end
         op_lui: begin
            dec.ctrl.regfilemux_sel = rfmux_u_imm;
            dec.ctrl.regfile_wb     = 1'b1;
         end
         op_jal: begin
            dec.ctrl.alumux1_sel    = alumux1_pc;
            dec.ctrl.alumux2_sel    = alumux2_j_imm;
            dec.ctrl.pcmux_sel      = pcmux_alu_out;
            dec.ctrl.regfilemux_sel = rfmux_pc_plus4;
            dec.ctrl.regfile_wb     = 1'b1;
         end
         op_jalr: begin
            dec.ctrl.pcmux_sel      = pcmux_alu_mod2;
            dec.ctrl.regfilemux_sel = rfmux_pc_plus4;
            dec.ctrl.regfile_wb     = 1'b1;
            dec.ctrl.rs1_read       = 1'b1;
         end
         op_br: begin
            dec.ctrl.alumux1_sel = alumux1_pc;
            dec.ctrl.alumux2_sel = alumux2_b_imm;
            dec.ctrl.pcmux_sel   = pcmux_br;
            dec.ctrl.use_cmp     = 1'b1;
            dec.ctrl.rs1_read    = 1'b1;
            dec.ctrl.rs2_read    = 1'b1;
         end
         op_load: begin
            dec.ctrl.d_read     = 1'b1;
            dec.ctrl.regfile_wb = 1'b1;
            dec.ctrl.rs1_read   = 1'b1;
            case (funct3)
               3'd0:    begin dec.ctrl.regfilemux_sel = rfmux_lb;  dec.ctrl.byte_enable = 4'b0001; end
               3'd1:    begin dec.ctrl.regfilemux_sel = rfmux_lh;  dec.ctrl.byte_enable = 4'b0011; end
               3'd2:    begin dec.ctrl.regfilemux_sel = rfmux_lw;  dec.ctrl.byte_enable = 4'b1111; end
               3'd4:    begin dec.ctrl.regfilemux_sel = rfmux_lbu; dec.ctrl.byte_enable = 4'b0001; end
               3'd5:    begin dec.ctrl.regfilemux_sel = rfmux_lhu; dec.ctrl.byte_enable = 4'b0011; end
               default: dec.illegal = 1'b1;
            endcase
         end
         op_store: begin
            dec.ctrl.alumux2_sel = alumux2_s_imm;
            dec.ctrl.d_write     = 1'b1;
            dec.ctrl.rs1_read    = 1'b1;
            dec.ctrl.rs2_read    = 1'b1;
            case (funct3)
               3'd0:    dec.ctrl.byte_enable = 4'b0001;
               3'd1:    dec.ctrl.byte_enable = 4'b0011;
               3'd2:    dec.ctrl.byte_enable = 4'b1111;
               default: dec.illegal = 1'b1;
            endcase
         end
         op_imm: begin
            dec.ctrl.regfile_wb = 1'b1;
            dec.ctrl.rs1_read   = 1'b1;
            case (funct3)
               3'd2: begin
                  dec.ctrl.cmpop = blt;  dec.ctrl.cmpmux_sel = cmpmux_i_imm;
                  dec.ctrl.regfilemux_sel = rfmux_br_en;
               end
               3'd3: begin
                  dec.ctrl.cmpop = bltu; dec.ctrl.cmpmux_sel = cmpmux_i_imm;
                  dec.ctrl.regfilemux_sel = rfmux_br_en;
               end
               3'd1: if (funct7 != 7'b0) dec.illegal = 1'b1;
               3'd5: begin
                  if (funct7 == 7'b0100000) dec.ctrl.aluop = alu_sra;
                  else if (funct7 != 7'b0)  dec.illegal = 1'b1;
               end
               default: ;
            endcase
         end
         op_reg: begin
            dec.ctrl.alumux2_sel = alumux2_rs2;
            dec.ctrl.regfile_wb  = 1'b1;
            dec.ctrl.rs1_read    = 1'b1;
            dec.ctrl.rs2_read    = 1'b1;
            if (funct7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
               dec.ctrl.aluop = alu_add;
               dec.muldiv     = 1'b1;
               dec.mdop       = funct3;
`else
               dec.illegal = 1'b1;
`endif
            end else if (funct7 == 7'b0100000) begin
               if (funct3 == 3'd0)      dec.ctrl.aluop = alu_sub;
               else if (funct3 == 3'd5) dec.ctrl.aluop = alu_sra;
               else                     dec.illegal = 1'b1;
            end else if (funct7 != 7'b0) begin
               dec.illegal = 1'b1;
            end else if (funct3 == 3'd2) begin
               dec.ctrl.cmpop = blt;  dec.ctrl.regfilemux_sel = rfmux_br_en;
            end else if (funct3 == 3'd3) begin
               dec.ctrl.cmpop = bltu; dec.ctrl.regfilemux_sel = rfmux_br_en;
            end
         end
         default: dec.illegal = 1'b1;
      endcase
      // Illegal entries must not touch architectural state downstream.
      if (dec.illegal) begin
         dec.ctrl.regfile_wb = 1'b0;
         dec.ctrl.d_read     = 1'b0;
         dec.ctrl.d_write    = 1'b0;
         dec.ctrl.pcmux_sel  = pcmux_pc_plus4;
`ifdef DECODE_RV32M_EN
         dec.muldiv          = 1'b0;
`endif
      end
   end

   // ---------------- queue control ----------------
   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head_nxt  = pop ? head + PTR_W'(1) : head;
   // The entry being pushed becomes the new head when the queue is empty after
   // this cycle's pop, so the head register takes it directly from decode.
   assign bypass    = push && (head_nxt == tail);

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: ;
      endcase
   end

   // NOTE: storage carries no reset; count and the pointers alone decide which slots are live.
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= dec;
   end

   // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         head_q <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         head  <= head_nxt;
         count <= count_nxt;
         // When the queue goes empty, the head register keeps the last head entry.
         if (count_nxt != '0) head_q <= bypass ? dec : mem[head_nxt];
      end
   end

   assign out_ctrl    = head_q.ctrl;
   assign out_pc      = head_q.pc;
   assign out_instr   = head_q.instr;
   assign out_illegal = head_q.illegal;
`ifdef DECODE_RV32M_EN
   assign out_muldiv  = head_q.muldiv;
   assign out_mdop    = head_q.mdop;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Directed testbench for decode_queue (DEPTH=4). Expected values are hand-derived
// from the RV32I encodings. Build with or without DECODE_RV32M_EN.
module tb_decode_queue;
   import decode_queue_pkg::*;

   logic              clk = 1'b0;
   logic              rst, in_valid, flush, out_ready;
   logic              in_ready, out_valid, out_illegal;
   logic [31:0]       in_instr, in_pc, out_pc, out_instr;
   rv32i_control_word out_ctrl;
   logic [2:0]        count;
`ifdef DECODE_RV32M_EN
   logic              out_muldiv;
   logic [2:0]        out_mdop;
`endif

   int errors = 0;
   int checks = 0;

   decode_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_pc(out_pc), .out_instr(out_instr), .out_illegal(out_illegal),
`ifdef DECODE_RV32M_EN
      .out_muldiv(out_muldiv), .out_mdop(out_mdop),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
      in_instr = instr; in_pc = pc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      tick(); tick();
      // Reset state
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_illegal", 32'(out_illegal), 0);
      check("rst_out_pc", out_pc, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_ctrl", 32'(out_ctrl), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      rst = 1'b1;
      tick();

      // addi x1,x0,5 with out_ready high
      in_instr = 32'h0050_0093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("addi_valid", 32'(out_valid), 1);
      check("addi_aluop", 32'(out_ctrl.aluop), 0);
      check("addi_wb", 32'(out_ctrl.regfile_wb), 1);
      check("addi_rs1_read", 32'(out_ctrl.rs1_read), 1);
      check("addi_illegal", 32'(out_illegal), 0);
      check("addi_pc", out_pc, 32'h100);
      tick();
      out_ready = 1'b0;
      check("addi_count_after_pop", 32'(count), 0);
      check("addi_valid_after_pop", 32'(out_valid), 0);
      check("addi_hold_pc", out_pc, 32'h100);

      // Fill to DEPTH, then offer a 5th
      for (int i = 0; i < 4; i++) begin
         check("fill_ready", 32'(in_ready), 1);
         push_one(32'h0050_0093, 32'h200 + 32'(4 * i));
      end
      check("full_count", 32'(count), 4);
      check("full_in_ready", 32'(in_ready), 0);
      push_one(32'h0050_0093, 32'h210);
      check("full_reject_count", 32'(count), 4);
      check("full_head_pc", out_pc, 32'h200);
      // Full with simultaneous pop: the push is still refused
      in_valid = 1'b1; in_pc = 32'h210; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("full_pop_count", 32'(count), 3);
      for (int i = 1; i < 4; i++) begin
         check("drain_pc", out_pc, 32'h200 + 32'(4 * i));
         tick();
      end
      out_ready = 1'b0;
      check("drain_count", 32'(count), 0);
      check("drain_valid", 32'(out_valid), 0);

      // lw then sw
      push_one(32'h0000_A103, 32'h300);
      push_one(32'h0020_A023, 32'h304);
      check("lw_d_read", 32'(out_ctrl.d_read), 1);
      check("lw_be", 32'(out_ctrl.byte_enable), 32'hF);
      check("lw_rfmux", 32'(out_ctrl.regfilemux_sel), 3);
      check("lw_wb", 32'(out_ctrl.regfile_wb), 1);
      pop_one();
      check("sw_pc", out_pc, 32'h304);
      check("sw_d_write", 32'(out_ctrl.d_write), 1);
      check("sw_be", 32'(out_ctrl.byte_enable), 32'hF);
      check("sw_wb", 32'(out_ctrl.regfile_wb), 0);
      check("sw_alumux2", 32'(out_ctrl.alumux2_sel), 3);
      pop_one();

      // All-ones word: illegal opcode, still queued
      push_one(32'hFFFF_FFFF, 32'h400);
      check("ill_valid", 32'(out_valid), 1);
      check("ill_flag", 32'(out_illegal), 1);
      check("ill_wb", 32'(out_ctrl.regfile_wb), 0);
      check("ill_d_write", 32'(out_ctrl.d_write), 0);
      check("ill_pcmux", 32'(out_ctrl.pcmux_sel), 0);
      pop_one();

      // sub x2,x1,x2
      push_one(32'h4020_8133, 32'h410);
      check("sub_aluop", 32'(out_ctrl.aluop), 3);
      check("sub_illegal", 32'(out_illegal), 0);
      check("sub_alumux2", 32'(out_ctrl.alumux2_sel), 5);
      pop_one();
      // slti x1,x1,5: comparator path
      push_one(32'h0050_A093, 32'h414);
      check("slti_rfmux", 32'(out_ctrl.regfilemux_sel), 1);
      check("slti_cmpop", 32'(out_ctrl.cmpop), 4);
      check("slti_cmpmux", 32'(out_ctrl.cmpmux_sel), 1);
      pop_one();
      // slli with funct7=0000001 is illegal
      push_one(32'h0200_9093, 32'h418);
      check("slli_bad_illegal", 32'(out_illegal), 1);
      check("slli_bad_wb", 32'(out_ctrl.regfile_wb), 0);
      pop_one();

      // Flush with three entries and a concurrent push
      for (int i = 0; i < 3; i++) push_one(32'h0050_0093, 32'h500 + 32'(4 * i));
      check("pre_flush_count", 32'(count), 3);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h50C;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count", 32'(count), 0);
      check("flush_valid", 32'(out_valid), 0);
      tick();
      check("flush_count_stays", 32'(count), 0);
      check("flush_in_ready", 32'(in_ready), 1);
      // A fresh push after flush lands at the head
      push_one(32'h0050_0093, 32'h600);
      check("post_flush_pc", out_pc, 32'h600);
      check("post_flush_count", 32'(count), 1);
      pop_one();

      // mul x3,x1,x2
      push_one(32'h0220_81B3, 32'h700);
`ifdef DECODE_RV32M_EN
      check("mul_illegal", 32'(out_illegal), 0);
      check("mul_muldiv", 32'(out_muldiv), 1);
      check("mul_mdop", 32'(out_mdop), 0);
      check("mul_wb", 32'(out_ctrl.regfile_wb), 1);
`else
      check("mul_illegal", 32'(out_illegal), 1);
      check("mul_wb", 32'(out_ctrl.regfile_wb), 0);
`endif
      pop_one();
      check("end_count", 32'(count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
